fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of instruction_memory.
- Holds the program counter and drives the memory's 48-bit address port.
- Captures the 32-bit combinational read into an IF/ID output register with a valid/ready handshake toward decode.
- Supports branch/jump redirect with squash, and halts on EBREAK.

---
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Owns the program counter, drives the
//                word address of instruction_memory, and captures the returned
//                instruction into an IF/ID register with a valid/ready
//                handshake toward decode. Supports redirect-with-squash and
//                halts after fetching EBREAK.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter logic [47:0] RESET_PC     = 48'h0,
   parameter logic [31:0] NOP_INSTR    = 32'h00000013,
   parameter logic [31:0] EBREAK_INSTR = 32'h00100073
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction memory (word-addressed, combinational read)
   output logic [47:0] imem_addr,
   input  logic [31:0] imem_instr,
   // control-flow redirect
   input  logic        redirect_valid,
   input  logic [47:0] redirect_pc,
   // IF/ID register toward decode
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [47:0] out_pc,
   // status
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [15:0] COUNT_MAX = 16'hFFFF;
   localparam logic [47:0] PC_STEP   = 48'd4;

   state_t      state;
   logic [47:0] pc;

   // Register slot is free when empty or being drained this cycle; a redirect
   // always wins so nothing is loaded from the stale path.
   logic        slot_free;
   logic        load;
   logic        load_is_ebreak;
   logic [47:0] redirect_target;

   // Byte-offset bits of the redirect target are architecturally ignored.
   logic        unused_redirect_lsbs;

   assign imem_addr            = {2'b00, pc[47:2]};
   assign slot_free            = !out_valid || out_ready;
   assign load                 = (state == ST_RUN) && slot_free && !redirect_valid;
   assign load_is_ebreak       = (imem_instr == EBREAK_INSTR);
   assign redirect_target      = {redirect_pc[47:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Fetch state machine: PC, IF/ID register, halt flag and fetch counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= NOP_INSTR;
         out_pc      <= 48'h0;
         halted      <= 1'b0;
         fetch_count <= 16'h0;
      end else if (redirect_valid) begin
         // Squash whatever is held, even if decode is accepting it this cycle,
         // and restart fetching at the aligned target on the next cycle.
         state     <= ST_RUN;
         pc        <= redirect_target;
         out_valid <= 1'b0;
         out_instr <= NOP_INSTR;
         halted    <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               // One settling cycle after reset release; nothing is fetched.
               state <= ST_RUN;
            end

            ST_RUN: begin
               if (load) begin
                  out_instr <= imem_instr;
                  out_pc    <= pc;
                  out_valid <= 1'b1;
                  pc        <= pc + PC_STEP;
                  if (fetch_count != COUNT_MAX) begin
                     fetch_count <= fetch_count + 16'd1;
                  end
                  // EBREAK is delivered like any instruction, then fetch stops.
                  if (load_is_ebreak) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end

            ST_HALT: begin
               // PC frozen; only let the held EBREAK drain to decode.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end

            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage with an accept-side
//                scoreboard and directed checks of boot, stall, redirect,
//                halt, asynchronous reset, PC wrap and counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] EBREAK = 32'h00100073;

   logic        clk;
   logic        rst_n;
   logic [47:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [47:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [47:0] out_pc;
   logic        halted;
   logic [15:0] fetch_count;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted),
      .fetch_count    (fetch_count)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [47:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sbq[$];

   logic [31:0] mem [64];
   logic        wrap_mode = 1'b0;
   logic        x_mode    = 1'b0;
   logic        sb_en     = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [47:0] a);
      if (wrap_mode || a >= 48'd64) return {8'hC3, a[23:0]};
      return mem[a[5:0]];
   endfunction

   always_comb begin
      imem_instr = mem_read(imem_addr);
      if (x_mode) imem_instr = 'x;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare every instruction decode actually accepts.
   always @(negedge clk) begin
      if (sb_en && rst_n && out_valid && out_ready && !redirect_valid) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 64'd0, 64'd1);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_pc", {16'h0, out_pc}, {16'h0, e.pc});
            chk("sb_instr", {32'h0, out_instr}, {32'h0, e.instr});
         end
      end
   end

   task automatic push_exp(input logic [47:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = mem[pc[7:2]];
      sbq.push_back(e);
   endtask

   // Expected stream from address 0 up to and including the EBREAK at 20.
   task automatic push_stream();
      for (int i = 0; i < 6; i++) push_exp(48'(i * 4));
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 48'h0;
      out_ready      = rdy;
      sbq.delete();
      @(negedge clk);
      chk("rst_valid", {63'h0, out_valid}, 64'd0);
      chk("rst_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("rst_pc", {16'h0, out_pc}, 64'd0);
      chk("rst_halted", {63'h0, halted}, 64'd0);
      chk("rst_count", {48'h0, fetch_count}, 64'd0);
      chk("rst_addr", {16'h0, imem_addr}, 64'd0);
      edge_step();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (halted && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain", {63'h0, ok}, 64'd1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 48'h0;
      out_ready      = 1'b0;
      mem[0] = 32'h00500093;
      mem[1] = 32'h00A00113;
      mem[2] = 32'h002081B3;
      mem[3] = 32'h00000013;
      for (int i = 4; i < 64; i++) mem[i] = {16'hA5A5, 16'(i)};
      mem[5] = EBREAK;

      // ---- boot and stream to EBREAK, then resume via redirect ----
      do_reset(1'b1);
      push_stream();
      @(negedge clk);
      chk("boot_valid", {63'h0, out_valid}, 64'd0);
      repeat (5) edge_step();
      @(negedge clk);
      chk("stream_count4", {48'h0, fetch_count}, 64'd4);
      chk("stream_pc12", {16'h0, out_pc}, 64'd12);
      wait_drain();
      chk("halt_addr", {16'h0, imem_addr}, 64'd6);
      chk("halt_count", {48'h0, fetch_count}, 64'd6);
      edge_step();
      chk("halt_frozen", {16'h0, imem_addr}, 64'd6);
      redirect_valid = 1'b1;
      redirect_pc    = 48'h0;
      push_stream();
      edge_step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("resume_halted", {63'h0, halted}, 64'd0);
      chk("resume_addr", {16'h0, imem_addr}, 64'd0);
      wait_drain();
      chk("sb_empty1", 64'(sbq.size()), 64'd0);

      // ---- backpressure ----
      do_reset(1'b1);
      push_stream();
      repeat (3) edge_step();
      out_ready = 1'b0;
      x_mode    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_pc", {16'h0, out_pc}, 64'd4);
         chk("stall_instr", {32'h0, out_instr}, {32'h0, mem[1]});
         chk("stall_addr", {16'h0, imem_addr}, 64'd2);
         chk("stall_count", {48'h0, fetch_count}, 64'd2);
         edge_step();
      end
      x_mode    = 1'b0;
      out_ready = 1'b1;
      edge_step();
      @(negedge clk);
      chk("resume_pc8", {16'h0, out_pc}, 64'd8);
      wait_drain();
      chk("sb_empty2", 64'(sbq.size()), 64'd0);

      // ---- redirect squash with misaligned target ----
      do_reset(1'b1);
      push_exp(48'h0);
      push_exp(48'h28);
      repeat (3) edge_step();
      redirect_valid = 1'b1;
      redirect_pc    = 48'h2A;
      edge_step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("squash_valid", {63'h0, out_valid}, 64'd0);
      chk("squash_addr", {16'h0, imem_addr}, 64'hA);
      chk("squash_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("squash_count", {48'h0, fetch_count}, 64'd2);
      edge_step();
      @(negedge clk);
      chk("target_valid", {63'h0, out_valid}, 64'd1);
      chk("target_pc", {16'h0, out_pc}, 64'h28);
      edge_step();
      out_ready = 1'b0;
      chk("sb_empty3", 64'(sbq.size()), 64'd0);

      // ---- asynchronous reset mid-run ----
      do_reset(1'b0);
      repeat (2) edge_step();
      @(negedge clk);
      chk("pre_areset_valid", {63'h0, out_valid}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_valid", {63'h0, out_valid}, 64'd0);
      chk("areset_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("areset_count", {48'h0, fetch_count}, 64'd0);
      chk("areset_addr", {16'h0, imem_addr}, 64'd0);

      // ---- PC wrap and counter saturation ----
      sb_en          = 1'b0;
      wrap_mode      = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 48'hFFFF_FFFF_FFFC;
      repeat (2) edge_step();
      rst_n = 1'b1;
      edge_step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_addr0", {16'h0, imem_addr}, 64'h3FFF_FFFF_FFFF);
      edge_step();
      @(negedge clk);
      chk("wrap_outpc", {16'h0, out_pc}, 64'hFFFF_FFFF_FFFC);
      chk("wrap_addr1", {16'h0, imem_addr}, 64'd0);
      chk("wrap_instr", {32'h0, out_instr}, {32'h0, 32'hC3FFFFFF});
      repeat (65533) edge_step();
      @(negedge clk);
      chk("cnt_fffe", {48'h0, fetch_count}, 64'hFFFE);
      edge_step();
      @(negedge clk);
      chk("cnt_ffff", {48'h0, fetch_count}, 64'hFFFF);
      repeat (70000 - 65535) edge_step();
      @(negedge clk);
      chk("cnt_sat", {48'h0, fetch_count}, 64'hFFFF);
      chk("long_pc", {16'h0, out_pc}, 64'd279992);
      chk("long_instr", {32'h0, out_instr}, {32'h0, 8'hC3, 24'd69998});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
